// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, GF(2^8) helpers and InvMixColumns FSM states.
package aes_pkg;
  localparam logic [7:0] AES_POLY = 8'h1B;
  typedef logic [127:0] aes_state_t;
  typedef logic [31:0] aes_word_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} imc_state_e;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/inv_mix_column_iter_if.sv
// inv_mix_column_iter_if: state in/out handshake bus plus busy flag (slave = the block).
interface inv_mix_column_iter_if;
  import aes_pkg::*;
  logic in_valid;
  logic in_ready;
  aes_state_t in_data;
  logic out_valid;
  logic out_ready;
  aes_state_t out_data;
  logic busy;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, busy);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/inv_mix_column_iter_col.sv
// inv_mix_single_column: combinational InvMixColumns of one column (col_i -> col_o, byte [31:24] = row 0).
module inv_mix_single_column
  import aes_pkg::*;
(
  input  aes_word_t col_i,
  output aes_word_t col_o
);
  logic [7:0] b0, b1, b2, b3, u, v, p0, p1, p2, p3, t;
  assign {b0, b1, b2, b3} = col_i;
  // Pre-multiply by {04}x^2+{05}, then the forward MixColumns gives the inverse matrix.
  assign u = xtime(xtime(b0 ^ b2));
  assign v = xtime(xtime(b1 ^ b3));
  assign {p0, p1, p2, p3} = {b0 ^ u, b1 ^ v, b2 ^ u, b3 ^ v};
  assign t = p0 ^ p1 ^ p2 ^ p3;
  assign col_o = {p0 ^ t ^ xtime(p0 ^ p1), p1 ^ t ^ xtime(p1 ^ p2),
                  p2 ^ t ^ xtime(p2 ^ p3), p3 ^ t ^ xtime(p3 ^ p0)};
endmodule

// File: rtl/inv_mix_column_iter.sv
// inv_mix_column_iter: iterative InvMixColumns, COLS_PER_CYCLE columns per clock; ports clk, rst, bus (slave).
module inv_mix_column_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst,
  inv_mix_column_iter_if.slave bus
);
  localparam int NUM_PASSES = 4 / COLS_PER_CYCLE;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  imc_state_e state_q, state_d;
  aes_state_t work_q, work_d, mixed;
  logic [1:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d, vld_q, vld_d, busy_q, busy_d;
  logic [1:0] idx [COLS_PER_CYCLE];
  aes_word_t col_out [COLS_PER_CYCLE];
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign idx[g] = 2'(int'(cnt_q) * COLS_PER_CYCLE + g);
    inv_mix_single_column u_col (.col_i(work_q[{idx[g], 5'b0} +: 32]), .col_o(col_out[g]));
  end
  always_comb begin
    mixed = work_q;
    for (int i = 0; i < COLS_PER_CYCLE; i++) mixed[{idx[i], 5'b0} +: 32] = col_out[i];
  end
  wire last = cnt_q == 2'(NUM_PASSES - 1);
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid && rdy_q) begin
        state_d = BUSY;
        work_d = bus.in_data;
        cnt_d = '0;
      end
      BUSY: begin
        work_d = mixed;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        state_d = last ? DONE : BUSY;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they settle on the same edge as the state.
    rdy_d = state_d == IDLE;
    vld_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      vld_q <= vld_d;
      busy_q <= busy_d;
    end
  end
  assign bus.in_ready = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data = work_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_inv_mix_column_iter.sv
// tb_inv_mix_column_iter: directed vectors, backpressure, reset abort and round-trip checks for 1/2/4 columns per cycle.
module tb_inv_mix_column_iter;
  logic clk = 0;
  logic rst = 0;
  logic iv [3];
  logic ordy [3];
  logic [127:0] id [3];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  inv_mix_column_iter_if b0 ();
  inv_mix_column_iter_if b1 ();
  inv_mix_column_iter_if b2 ();
  assign b0.in_valid = iv[0];
  assign b0.in_data = id[0];
  assign b0.out_ready = ordy[0];
  assign b1.in_valid = iv[1];
  assign b1.in_data = id[1];
  assign b1.out_ready = ordy[1];
  assign b2.in_valid = iv[2];
  assign b2.in_data = id[2];
  assign b2.out_ready = ordy[2];
  inv_mix_column_iter #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b0));
  inv_mix_column_iter #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(b1));
  inv_mix_column_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(b2));

  function automatic logic rdy(int k);
    return k == 0 ? b0.in_ready : k == 1 ? b1.in_ready : b2.in_ready;
  endfunction
  function automatic logic vld(int k);
    return k == 0 ? b0.out_valid : k == 1 ? b1.out_valid : b2.out_valid;
  endfunction
  function automatic logic bsy(int k);
    return k == 0 ? b0.busy : k == 1 ? b1.busy : b2.busy;
  endfunction
  function automatic logic [127:0] dat(int k);
    return k == 0 ? b0.out_data : k == 1 ? b1.out_data : b2.out_data;
  endfunction

  function automatic logic [7:0] xt(logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction
  function automatic logic [31:0] fmix(logic [31:0] w);
    logic [7:0] a0, a1, a2, a3, s;
    {a0, a1, a2, a3} = w;
    s = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ s ^ xt(a0 ^ a1), a1 ^ s ^ xt(a1 ^ a2), a2 ^ s ^ xt(a2 ^ a3), a3 ^ s ^ xt(a3 ^ a0)};
  endfunction
  function automatic logic [127:0] fmix_state(logic [127:0] s);
    return {fmix(s[127:96]), fmix(s[95:64]), fmix(s[63:32]), fmix(s[31:0])};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer with out_ready low until the result appears; returns result and latency in edges.
  task automatic xfer(input int k, input logic [127:0] d, output logic [127:0] r, output int lat);
    int w = 0;
    while (!rdy(k) && w < 20) begin
      tick();
      w++;
    end
    chk("wait_in_ready", 128'(rdy(k)), 128'(1));
    iv[k] = 1;
    id[k] = d;
    tick();
    iv[k] = 0;
    id[k] = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!vld(k) && lat < 20) begin
      tick();
      lat++;
    end
    r = dat(k);
    chk("done_in_ready_low", 128'(rdy(k)), 128'(0));
    ordy[k] = 1;
    tick();
    ordy[k] = 0;
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [5];

  initial begin
    logic [127:0] r, x, got;
    int lat, sent, recv, cyc;
    logic [127:0] q [$];
    logic acc, outx;
    vecs[0] = '{{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6},
                {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6}};
    vecs[1] = '{{4{32'hd5d5d7d6}}, {4{32'hd4d4d4d5}}};
    vecs[2] = '{{32'h4d7ebdf8, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hd5d5d7d6},
                {32'h2d26314c, 32'hd4d4d4d5, 32'h2d26314c, 32'hd4d4d4d5}};
    vecs[3] = '{{32'hd5d5d7d6, 32'h4d7ebdf8, 32'hd5d5d7d6, 32'h4d7ebdf8},
                {32'hd4d4d4d5, 32'h2d26314c, 32'hd4d4d4d5, 32'h2d26314c}};
    vecs[4] = '{128'h0, 128'h0};
    for (int k = 0; k < 3; k++) begin
      iv[k] = 0;
      ordy[k] = 0;
      id[k] = '0;
    end
    #1 rst = 1;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("reset_out_valid", 128'(vld(k)), 128'(0));
      chk("reset_in_ready", 128'(rdy(k)), 128'(0));
      chk("reset_busy", 128'(bsy(k)), 128'(0));
      chk("reset_out_data", dat(k), 128'h0);
    end
    tick();
    tick();
    rst = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        xfer(k, vecs[i].din, r, lat);
        chk($sformatf("vec%0d_cpc%0d_data", i, 1 << k), r, vecs[i].dout);
        chk($sformatf("vec%0d_cpc%0d_latency", i, 1 << k), 128'(lat), 128'(4 >> k));
      end
    end
    // Idle: toggling data without valid must not start anything.
    for (int i = 0; i < 6; i++) begin
      id[0] = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk("idle_out_valid", 128'(vld(0)), 128'(0));
      chk("idle_busy", 128'(bsy(0)), 128'(0));
      chk("idle_in_ready", 128'(rdy(0)), 128'(1));
    end
    // Backpressure with a stray in_valid pulse while DONE.
    iv[0] = 1;
    id[0] = vecs[0].din;
    tick();
    iv[0] = 0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 10; i++) begin
      iv[0] = i == 3;
      id[0] = vecs[1].din;
      chk("bp_out_valid", 128'(vld(0)), 128'(1));
      chk("bp_out_data", dat(0), vecs[0].dout);
      chk("bp_in_ready", 128'(rdy(0)), 128'(0));
      tick();
    end
    iv[0] = 0;
    ordy[0] = 1;
    tick();
    ordy[0] = 0;
    chk("bp_release_out_valid", 128'(vld(0)), 128'(0));
    chk("bp_release_in_ready", 128'(rdy(0)), 128'(1));
    for (int i = 0; i < 3; i++) tick();
    chk("bp_stray_not_captured", 128'(bsy(0)), 128'(0));
    // Asynchronous reset partway through BUSY.
    iv[0] = 1;
    id[0] = vecs[2].din;
    tick();
    iv[0] = 0;
    tick();
    tick();
    #2 rst = 1;
    #1;
    chk("rst_mid_out_valid", 128'(vld(0)), 128'(0));
    chk("rst_mid_busy", 128'(bsy(0)), 128'(0));
    chk("rst_mid_out_data", dat(0), 128'h0);
    chk("rst_mid_in_ready", 128'(rdy(0)), 128'(0));
    tick();
    #2 rst = 0;
    xfer(0, vecs[3].din, r, lat);
    chk("post_rst_data", r, vecs[3].dout);
    chk("post_rst_latency", 128'(lat), 128'(4));
    // Back-to-back round trip through the forward model.
    for (int k = 0; k < 3; k++) begin
      q = {};
      sent = 0;
      recv = 0;
      cyc = 0;
      x = {$urandom, $urandom, $urandom, $urandom};
      q.push_back(x);
      id[k] = fmix_state(x);
      iv[k] = 1;
      ordy[k] = 1;
      while (recv < 1000 && cyc < 10000) begin
        acc = rdy(k) && iv[k];
        outx = vld(k);
        if (outx) begin
          got = q.size() > 0 ? q.pop_front() : 128'hx;
          chk($sformatf("roundtrip_cpc%0d_%0d", 1 << k, recv), dat(k), got);
          recv++;
        end
        tick();
        cyc++;
        if (acc) begin
          sent++;
          if (sent < 1000) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            q.push_back(x);
            id[k] = fmix_state(x);
          end else iv[k] = 0;
        end
      end
      iv[k] = 0;
      ordy[k] = 0;
      chk($sformatf("roundtrip_cpc%0d_count", 1 << k), 128'(recv), 128'(1000));
      chk($sformatf("roundtrip_cpc%0d_sent", 1 << k), 128'(sent), 128'(1000));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
